// File: rtl/reg_scoreboard_pkg.sv
// Shared encodings for the register scoreboard: operand forwarding sources
// and per-register producer ages.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ADDR_SPACE = 1 << REG_ADDR_W;

    // The numeric values deliberately match: a producer at age N is forwarded from source N.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_EX      = 2'd1,
        FWD_MEM     = 2'd2,
        FWD_WB      = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        AGE_FREE = 2'd0,
        AGE_EX   = 2'd1,
        AGE_MEM  = 2'd2,
        AGE_WB   = 2'd3
    } age_e;

endpackage

// File: rtl/reg_sb_entry.sv
// One architectural register's scoreboard state: age of its youngest
// in-flight producer plus whether that producer is a load.
module reg_sb_entry
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic is_load,
    input  logic advance,
    output age_e age,
    output logic load
);

    // NOTE: state is updated with non-blocking assignments so every entry
    // samples the pre-edge values, like real flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age  <= AGE_FREE;
            load <= 1'b0;
        end else if (issue) begin
            // A new producer overrides any older one, even one retiring this edge.
            age  <= AGE_EX;
            load <= is_load;
        end else if (advance) begin
            unique case (age)
                AGE_FREE: age <= AGE_FREE;
                AGE_EX:   age <= AGE_MEM;
                AGE_MEM:  age <= AGE_WB;
                AGE_WB: begin
                    age  <= AGE_FREE;
                    load <= 1'b0;
                end
                default:  age <= AGE_FREE;
            endcase
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a 5-stage pipeline: tracks in-flight producers,
// selects operand forwarding sources and requests a load-use stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  reg_read_en_1,
    input  logic                  reg_read_en_2,
    input  logic [REG_ADDR_W-1:0] reg_addr_1,
    input  logic [REG_ADDR_W-1:0] reg_addr_2,
    input  logic                  reg_write_en,
    input  logic [REG_ADDR_W-1:0] reg_write_addr,
    input  logic                  id_is_load,
    input  logic                  pipe_stall,
    output logic                  stall_req,
    output logic [1:0]            fwd_sel_1,
    output logic [1:0]            fwd_sel_2
);

    // Sized to the full address space so any address indexes safely;
    // entry 0 and entries beyond NUM_REGS read as permanently free.
    age_e age_q  [ADDR_SPACE];
    logic load_q [ADDR_SPACE];
    logic issue;
    logic hazard_1;
    logic hazard_2;

    assign issue = id_valid & ~stall_req & ~pipe_stall;

    assign age_q[0]  = AGE_FREE;
    assign load_q[0] = 1'b0;

    for (genvar r = 1; r < ADDR_SPACE; r++) begin : g_entry
        if (r < NUM_REGS) begin : g_tracked
            reg_sb_entry u_entry (
                .clk     (clk),
                .rst     (rst),
                .issue   (issue & reg_write_en & (reg_write_addr == REG_ADDR_W'(r))),
                .is_load (id_is_load),
                .advance (~pipe_stall),
                .age     (age_q[r]),
                .load    (load_q[r])
            );
        end else begin : g_untracked
            assign age_q[r]  = AGE_FREE;
            assign load_q[r] = 1'b0;
        end
    end

    // Lookup reads the pre-edge state, so an instruction reading its own
    // destination sees the previous producer rather than itself.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        fwd_sel_1 = FWD_REGFILE;
        fwd_sel_2 = FWD_REGFILE;
        hazard_1  = 1'b0;
        hazard_2  = 1'b0;
        if (reg_read_en_1 && reg_addr_1 != '0) begin
            fwd_sel_1 = age_q[reg_addr_1];
            hazard_1  = (age_q[reg_addr_1] == AGE_EX) && load_q[reg_addr_1];
        end
        if (reg_read_en_2 && reg_addr_2 != '0) begin
            fwd_sel_2 = age_q[reg_addr_2];
            hazard_2  = (age_q[reg_addr_2] == AGE_EX) && load_q[reg_addr_2];
        end
    end

    assign stall_req = id_valid & (hazard_1 | hazard_2);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed pipeline scenarios with
// literal expectations plus a per-cycle comparison against a timestamp model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic       reg_read_en_1 = 1'b0;
    logic       reg_read_en_2 = 1'b0;
    logic [4:0] reg_addr_1 = '0;
    logic [4:0] reg_addr_2 = '0;
    logic       reg_write_en = 1'b0;
    logic [4:0] reg_write_addr = '0;
    logic       id_is_load = 1'b0;
    logic       pipe_stall = 1'b0;
    logic       stall_req;
    logic [1:0] fwd_sel_1;
    logic [1:0] fwd_sel_2;

    int errors = 0;
    int checks = 0;

    reg_scoreboard #(.NUM_REGS(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .reg_read_en_1  (reg_read_en_1),
        .reg_read_en_2  (reg_read_en_2),
        .reg_addr_1     (reg_addr_1),
        .reg_addr_2     (reg_addr_2),
        .reg_write_en   (reg_write_en),
        .reg_write_addr (reg_write_addr),
        .id_is_load     (id_is_load),
        .pipe_stall     (pipe_stall),
        .stall_req      (stall_req),
        .fwd_sel_1      (fwd_sel_1),
        .fwd_sel_2      (fwd_sel_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: each register remembers the pipeline-advance count at which its
    // youngest producer issued; its age is simply how far the pipe moved since.
    int ticks = 0;
    int issued_at [32];
    bit was_load  [32];

    function automatic int m_age(input logic [4:0] addr);
        int a;
        if (addr == 0 || issued_at[addr] < 0) return 0;
        a = ticks - issued_at[addr] + 1;
        return (a >= 1 && a <= 3) ? a : 0;
    endfunction

    function automatic int m_fwd(input logic en, input logic [4:0] addr);
        return en ? m_age(addr) : 0;
    endfunction

    function automatic int m_stall();
        bit h1, h2;
        h1 = reg_read_en_1 && reg_addr_1 != 0 && m_age(reg_addr_1) == 1 && was_load[reg_addr_1];
        h2 = reg_read_en_2 && reg_addr_2 != 0 && m_age(reg_addr_2) == 1 && was_load[reg_addr_2];
        return (id_valid && (h1 || h2)) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ticks = 0;
            for (int i = 0; i < 32; i++) begin
                issued_at[i] = -1;
                was_load[i]  = 1'b0;
            end
        end else begin
            bit do_issue;
            do_issue = id_valid && m_stall() == 0 && !pipe_stall;
            if (!pipe_stall) ticks++;
            if (do_issue && reg_write_en && reg_write_addr != 0) begin
                issued_at[reg_write_addr] = ticks;
                was_load[reg_write_addr]  = id_is_load;
            end
        end
    end

    bit compare_on = 1'b0;
    always @(negedge clk) begin
        if (compare_on) begin
            check("model_fwd_sel_1", int'(fwd_sel_1), m_fwd(reg_read_en_1, reg_addr_1));
            check("model_fwd_sel_2", int'(fwd_sel_2), m_fwd(reg_read_en_2, reg_addr_2));
            check("model_stall_req", int'(stall_req), m_stall());
        end
    end

    // Present one ID-stage instruction just after the edge; outputs settle by +1.
    task automatic present(input logic v, input logic re1, input logic [4:0] a1,
                           input logic re2, input logic [4:0] a2, input logic we,
                           input logic [4:0] wa, input logic ld, input logic ps);
        id_valid = v; reg_read_en_1 = re1; reg_addr_1 = a1;
        reg_read_en_2 = re2; reg_addr_2 = a2; reg_write_en = we;
        reg_write_addr = wa; id_is_load = ld; pipe_stall = ps;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int f1, input int f2, input int st);
        check({name, "_fwd1"}, int'(fwd_sel_1), f1);
        check({name, "_fwd2"}, int'(fwd_sel_2), f2);
        check({name, "_stall"}, int'(stall_req), st);
    endtask

    initial begin
        compare_on = 1'b1;
        #12;
        expect_out("reset_idle", 0, 0, 0);
        present(1, 1, 5'd3, 1, 5'd4, 0, 0, 0, 0);
        expect_out("reset_reads", 0, 0, 0);
        rst = 1'b0;
        step();

        // ALU producer r8, then readers at ages 1, 2, 3 and retired
        present(1, 0, 0, 0, 0, 1, 5'd8, 0, 0); step();
        present(1, 1, 5'd8, 0, 0, 0, 0, 0, 0); expect_out("alu_age1", 1, 0, 0); step();
        present(1, 1, 5'd8, 0, 0, 0, 0, 0, 0); expect_out("alu_age2", 2, 0, 0); step();
        present(1, 1, 5'd8, 0, 0, 0, 0, 0, 0); expect_out("alu_age3", 3, 0, 0); step();
        present(1, 1, 5'd8, 0, 0, 0, 0, 0, 0); expect_out("alu_retired", 0, 0, 0); step();

        // Load-use on r9: exactly one bubble, then MEM forwarding
        present(1, 0, 0, 0, 0, 1, 5'd9, 1, 0); step();
        present(1, 0, 0, 1, 5'd9, 0, 0, 0, 0); expect_out("load_use", 0, 1, 1); step();
        expect_out("load_use_after", 0, 2, 0); step();

        // Two producers of r10 back to back: youngest wins
        present(1, 0, 0, 0, 0, 1, 5'd10, 0, 0); step();
        present(1, 0, 0, 0, 0, 1, 5'd10, 0, 0); step();
        present(1, 1, 5'd10, 0, 0, 0, 0, 0, 0); expect_out("youngest", 1, 0, 0); step();
        // Reader of its own destination sees the prior producer
        present(1, 1, 5'd10, 0, 0, 1, 5'd10, 0, 0); expect_out("self_read", 2, 0, 0); step();
        present(1, 1, 5'd10, 0, 0, 0, 0, 0, 0); expect_out("self_after", 1, 0, 0); step();

        // Load r11 frozen by pipe_stall for three cycles
        present(1, 0, 0, 0, 0, 1, 5'd11, 1, 0); step();
        present(1, 1, 5'd11, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            expect_out("frozen", 1, 0, 1);
            step();
        end
        present(1, 1, 5'd11, 0, 0, 0, 0, 0, 0); expect_out("released", 1, 0, 1); step();
        expect_out("released_mem", 2, 0, 0); step();
        expect_out("released_wb", 3, 0, 0); step();

        // Register 0 is never tracked; disabled read of a busy load is ignored
        present(1, 0, 0, 0, 0, 1, 5'd0, 1, 0); step();
        present(1, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0); expect_out("r0_read", 0, 0, 0); step();
        present(1, 0, 0, 0, 0, 1, 5'd13, 1, 0); step();
        present(1, 0, 5'd13, 0, 5'd13, 0, 0, 0, 0); expect_out("read_disabled", 0, 0, 0); step();

        // Both operands on the same register
        present(1, 0, 0, 0, 0, 1, 5'd14, 0, 0); step();
        present(1, 1, 5'd14, 1, 5'd14, 0, 0, 0, 0); expect_out("same_reg", 1, 1, 0); step();

        // Re-issue into an entry retiring on the same edge
        present(1, 0, 0, 0, 0, 1, 5'd15, 0, 0); step();
        present(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
        present(1, 1, 5'd15, 0, 0, 1, 5'd15, 0, 0); expect_out("retire_age3", 3, 0, 0); step();
        present(1, 1, 5'd15, 0, 0, 0, 0, 0, 0); expect_out("retire_reissue", 1, 0, 0); step();

        // Reset pulse mid-flight clears r12 immediately
        present(1, 0, 0, 0, 0, 1, 5'd12, 1, 0); step();
        present(1, 1, 5'd12, 0, 0, 0, 0, 0, 0); step();
        expect_out("pre_reset", 2, 0, 0);
        rst = 1'b1; #1;
        expect_out("async_reset", 0, 0, 0);
        #1 rst = 1'b0;
        step();
        expect_out("post_reset", 0, 0, 0);
        // First issue after reset is accepted on the next edge
        present(1, 0, 0, 0, 0, 1, 5'd12, 0, 0); step();
        present(1, 1, 5'd12, 0, 0, 0, 0, 0, 0); expect_out("first_issue", 1, 0, 0); step();

        present(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
        compare_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
